// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART TX core between NUM_REQ byte streams.
// Optional lock-idle timeout enabled by defining UART_ARB_LOCK_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  parameter int LOCK_TIMEOUT  = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [8*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_data_valid,
  input  logic                         tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         locked,
  output logic                         start_err,
  output logic                         lock_to_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SCW = $clog2(START_TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [7:0]         r_tx_data;
  logic               r_tx_data_valid;
  logic [IDW-1:0]     r_grant_id;
  logic               r_locked;
  logic               r_start_err;
  logic [SCW-1:0]     r_start_cnt;

  logic [NUM_REQ-1:0] w_eligible;
  logic [IDW-1:0]     w_pick;
  logic               w_pick_valid;
  logic [IDW:0]       w_sum;
  logic [IDW-1:0]     w_idx;
  logic               w_accept;
  logic [7:0]         w_pick_data;
  logic               w_pick_last;
  logic               w_lock_expire;

  // While locked only the owner may compete; otherwise everyone does.
  always_comb begin
    if (r_locked) begin
      w_eligible = req_valid & (ONE_HOT0 << r_grant_id);
    end else begin
      w_eligible = req_valid;
    end
  end

  // Rotating priority: scan down from the farthest offset so the nearest eligible one after grant_id wins.
  always_comb begin
    w_pick       = r_grant_id;
    w_pick_valid = 1'b0;
    w_sum        = {(IDW+1){1'b0}};
    w_idx        = {IDW{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_sum = {1'b0, r_grant_id} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDW+1)'(NUM_REQ);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[IDW-1:0];
      if (w_eligible[w_idx]) begin
        w_pick       = w_idx;
        w_pick_valid = 1'b1;
      end else begin
        w_pick       = w_pick;
        w_pick_valid = w_pick_valid;
      end
    end
  end

  assign w_accept    = (r_state == ST_IDLE) && !tx_busy && w_pick_valid;
  assign w_pick_data = req_data[{w_pick, 3'b000} +: 8];
  assign w_pick_last = req_last[w_pick];

  // Handshake is combinational so the byte is taken in the same cycle it is offered.
  always_comb begin
    if (w_accept && reset) begin
      req_ready = ONE_HOT0 << w_pick;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
  localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
  logic [LCW-1:0] r_lock_cnt;
  logic           r_lock_to_err;
  logic           w_lock_idle;

  assign w_lock_idle   = (r_state == ST_IDLE) && r_locked && !req_valid[r_grant_id];
  assign w_lock_expire = w_lock_idle && (r_lock_cnt == LCW'(LOCK_TIMEOUT - 1));

  // Counts cycles an owner holds the lock without offering data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock_cnt    <= {LCW{1'b0}};
      r_lock_to_err <= 1'b0;
    end else begin
      if (w_accept || w_lock_expire) begin
        r_lock_cnt <= {LCW{1'b0}};
      end else if (w_lock_idle) begin
        r_lock_cnt <= r_lock_cnt + LCW'(1);
      end else begin
        r_lock_cnt <= r_lock_cnt;
      end
      r_lock_to_err <= r_lock_to_err | w_lock_expire;
    end
  end

  assign lock_to_err = r_lock_to_err;
`else
  logic [31:0] w_unused_lock_timeout;
  assign w_unused_lock_timeout = 32'(LOCK_TIMEOUT);
  assign w_lock_expire         = 1'b0;
  assign lock_to_err           = 1'b0;
`endif

  // Byte sequencer: accept, pulse the UART, wait for busy to rise then fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_tx_data       <= 8'h00;
      r_tx_data_valid <= 1'b0;
      r_grant_id      <= IDW'(NUM_REQ - 1);
      r_locked        <= 1'b0;
      r_start_err     <= 1'b0;
      r_start_cnt     <= {SCW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tx_data       <= w_pick_data;
            r_grant_id      <= w_pick;
            r_locked        <= ~w_pick_last;
            r_tx_data_valid <= 1'b1;
            r_state         <= ST_SEND;
          end else if (w_lock_expire) begin
            r_locked        <= 1'b0;
            r_tx_data_valid <= 1'b0;
          end else begin
            r_tx_data_valid <= 1'b0;
          end
        end
        ST_SEND: begin
          r_tx_data_valid <= 1'b0;
          r_start_cnt     <= {SCW{1'b0}};
          r_state         <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_start_cnt == SCW'(START_TIMEOUT - 1)) begin
            // UART never started: drop the byte and flag it.
            r_start_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_start_cnt <= r_start_cnt + SCW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT_DONE;
          end
        end
        default: begin
          r_state         <= ST_IDLE;
          r_tx_data_valid <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data       = r_tx_data;
  assign tx_data_valid = r_tx_data_valid;
  assign grant_id      = r_grant_id;
  assign locked        = r_locked;
  assign start_err     = r_start_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic
// compared against a queue-based arbitration model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [7:0]      tx_data;
  logic            tx_data_valid;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            locked;
  logic            start_err;
  logic            lock_to_err;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(16), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .grant_id(grant_id),
    .locked(locked), .start_err(start_err), .lock_to_err(lock_to_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pending bytes per requester: {last, data}
  logic [8:0] q[N][$];
  int         m_grant;
  bit         m_locked;
  bit         always_valid;
  int         p;
  int         exp_seq[5];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner = valid requester at the smallest forward distance from the last grant.
  function automatic int model_pick(input logic [N-1:0] mask);
    int best;
    int bestd;
    best  = -1;
    bestd = N;
    if (m_locked) return mask[m_grant] ? m_grant : -1;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        int d;
        d = (i - m_grant - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  // One arbitration slot, entered and left on a negedge with the DUT idle.
  // mode 0: random UART timing, 1: busy for busy_len cycles, 2: return right after the pulse.
  task automatic step(input int mode, input int busy_len, output int picked);
    logic [N-1:0] mask;
    logic [8:0]   e;
    logic [7:0]   exp_byte;
    int           d;
    int           h;
    mask = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        if (always_valid || (m_locked && i == m_grant) || $urandom_range(0, 3) != 0) mask[i] = 1'b1;
        e = q[i][0];
        req_data[8*i +: 8] = e[7:0];
        req_last[i]        = e[8];
      end else begin
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    req_valid = mask;
    tx_busy   = 1'b0;
    #1;
    picked = model_pick(mask);
    check_val("req_ready", {28'd0, req_ready}, (picked < 0) ? 32'd0 : (32'd1 << picked));
    if (picked < 0) begin
      @(negedge clk);
      return;
    end
    e        = q[picked].pop_front();
    exp_byte = e[7:0];
    m_grant  = picked;
    m_locked = !e[8];
    @(negedge clk);
    req_valid = '0;
    check_val("pulse", {31'd0, tx_data_valid}, 32'd1);
    check_val("tx_data", {24'd0, tx_data}, {24'd0, exp_byte});
    check_val("grant_id", {30'd0, grant_id}, picked);
    check_val("locked", {31'd0, locked}, {31'd0, m_locked});
    check_val("ready_busy", {28'd0, req_ready}, 32'd0);
    if (mode == 2) return;
    d = (mode == 0) ? $urandom_range(0, 3) : 0;
    h = (mode == 0) ? $urandom_range(3, 8) : busy_len;
    repeat (d) begin
      @(negedge clk);
      check_val("pulse_once", {31'd0, tx_data_valid}, 32'd0);
    end
    tx_busy = 1'b1;
    repeat (h) begin
      @(negedge clk);
      check_val("pulse_once", {31'd0, tx_data_valid}, 32'd0);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    check_val("tx_data_hold", {24'd0, tx_data}, {24'd0, exp_byte});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    m_grant = N - 1; m_locked = 1'b0; always_valid = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check_val("rst_ready", {28'd0, req_ready}, 32'd0);
    check_val("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_val("rst_valid", {31'd0, tx_data_valid}, 32'd0);
    check_val("rst_grant", {30'd0, grant_id}, 32'd3);
    check_val("rst_locked", {31'd0, locked}, 32'd0);
    check_val("rst_errs", {30'd0, start_err, lock_to_err}, 32'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;

    // All requesters valid, single-byte packets: plain rotation from 0.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++) begin
        b = 8'(16 * i + j + 1);
        q[i].push_back({1'b1, b});
      end
    exp_seq = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      step(1, 10, p);
      check_val("rr_order", {30'd0, grant_id}, exp_seq[k]);
    end
    clear_queues();

    // Requester 1 locks the UART for a three-byte packet.
    q[1].push_back({1'b0, 8'h41});
    q[1].push_back({1'b0, 8'h42});
    q[1].push_back({1'b1, 8'h43});
    for (int k = 0; k < 4; k++) begin
      q[0].push_back({1'b1, 8'hA0});
      q[2].push_back({1'b1, 8'hC0});
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 5, p);
      check_val("pkt_grant", {30'd0, grant_id}, 32'd1);
      check_val("pkt_lock", {31'd0, locked}, (k < 2) ? 32'd1 : 32'd0);
    end
    step(1, 5, p);
    check_val("after_pkt_grant", {30'd0, grant_id}, 32'd2);
    clear_queues();

    // UART never raises busy: start timeout after 16 cycles in WAIT_START.
    q[0].push_back({1'b1, 8'h77});
    step(2, 0, p);
    repeat (16) @(negedge clk);
    check_val("start_err_early", {31'd0, start_err}, 32'd0);
    @(negedge clk);
    check_val("start_err_set", {31'd0, start_err}, 32'd1);
    q[3].push_back({1'b1, 8'h78});
    step(1, 4, p);
    check_val("after_timeout_grant", {30'd0, grant_id}, 32'd3);

    // UART busy while idle: nothing accepted until it falls.
    q[0].push_back({1'b1, 8'h33});
    tx_busy = 1'b1; req_valid = 4'b0001; req_data[7:0] = 8'h33; req_last = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("busy_idle_ready", {28'd0, req_ready}, 32'd0);
      check_val("busy_idle_pulse", {31'd0, tx_data_valid}, 32'd0);
      @(negedge clk);
    end
    step(1, 4, p);

    // Async reset in WAIT_DONE while requester 2 holds the lock.
    req_valid = 4'b0100; req_data[23:16] = 8'h5A; req_last = 4'b0000;
    #1;
    check_val("pre_rst_ready", {28'd0, req_ready}, 32'd4);
    @(negedge clk);
    check_val("pre_rst_locked", {31'd0, locked}, 32'd1);
    req_valid = '0;
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 4'b1111;
    #2 reset = 1'b0;
    #1;
    check_val("arst_ready", {28'd0, req_ready}, 32'd0);
    check_val("arst_tx_data", {24'd0, tx_data}, 32'd0);
    check_val("arst_grant", {30'd0, grant_id}, 32'd3);
    check_val("arst_locked", {31'd0, locked}, 32'd0);
    check_val("arst_start_err", {31'd0, start_err}, 32'd0);
    tx_busy = 1'b0; req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    m_grant = N - 1; m_locked = 1'b0;
    clear_queues();
    for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'hE0 + 8'(i))});
    step(1, 3, p);
    check_val("post_rst_grant", {30'd0, grant_id}, 32'd0);
    clear_queues();

    // Owner 2 leaves the lock idle while requester 3 waits.
    q[2].push_back({1'b0, 8'h66});
    step(1, 3, p);
    q[2].delete();
    req_valid = 4'b1000; req_data[31:24] = 8'h99; req_last = 4'b1000;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        check_val("lock_held", {31'd0, locked}, 32'd1);
      end else begin
        check_val("lock_to_released", {31'd0, locked}, 32'd0);
        check_val("lock_to_err", {31'd0, lock_to_err}, 32'd1);
        check_val("lock_to_ready", {28'd0, req_ready}, 32'd8);
      end
    end
    m_locked = 1'b0;
    q[3].push_back({1'b1, 8'h99});
    step(1, 3, p);
    check_val("lock_to_grant", {30'd0, grant_id}, 32'd3);
`else
    repeat (20) @(negedge clk);
    #1;
    check_val("lock_forever", {31'd0, locked}, 32'd1);
    check_val("lock_forever_ready", {28'd0, req_ready}, 32'd0);
    check_val("lock_to_err_tied", {31'd0, lock_to_err}, 32'd0);
    q[2].push_back({1'b1, 8'h67});
    q[3].push_back({1'b1, 8'h99});
    step(1, 3, p);
    check_val("owner_finishes", {30'd0, grant_id}, 32'd2);
    step(1, 3, p);
    check_val("next_after_owner", {30'd0, grant_id}, 32'd3);
`endif
    clear_queues();

    // Randomized multi-byte packet traffic with random valid gaps and UART timing.
    always_valid = 1'b0;
    for (int it = 0; it < 200; it++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 2) == 0) begin
          int len;
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++) begin
            b = 8'($urandom_range(0, 255));
            q[i].push_back({(j == len - 1) ? 1'b1 : 1'b0, b});
          end
        end
      end
      step(0, 0, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
